// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts PATTERN out MSB first, `count` times, with start/ready/done handshake.
// Define SEQ_TX_GAP_EN to insert one idle cycle between consecutive repetitions.
module seq_pattern_tx #(
    parameter int unsigned           PAT_W   = 3,
    parameter logic [PAT_W-1:0]      PATTERN = 3'b101,
    parameter int unsigned           CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             ready,
    output logic             x,
    output logic             valid,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

`ifdef SEQ_TX_GAP_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2,
        ST_GAP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;
`endif

    state_t             state, state_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               x_d, valid_d, last_d, busy_d, done_d;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            cnt   <= '0;
            x     <= 1'b0;
            valid <= 1'b0;
            last  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            cnt   <= cnt_d;
            x     <= x_d;
            valid <= valid_d;
            last  <= last_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Next state; outputs are precomputed from the next state so they are valid right after the edge
    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt;
        x_d     = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_d = ST_SEND;
                        cnt_d   = count;
                        idx_d   = IDX_W'(PAT_W - 1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SEND: begin
                if (idx == '0) begin
                    if (cnt == CNT_W'(1)) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt - CNT_W'(1);
                        idx_d   = IDX_W'(PAT_W - 1);
`ifdef SEQ_TX_GAP_EN
                        state_d = ST_GAP;
`else
                        state_d = ST_SEND;
`endif
                    end
                end else begin
                    idx_d = idx - IDX_W'(1);
                end
            end
`ifdef SEQ_TX_GAP_EN
            ST_GAP: begin
                state_d = ST_SEND;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = (state_d == ST_SEND);
        x_d     = valid_d & PATTERN[idx_d];
        last_d  = valid_d && (idx_d == '0);
        done_d  = (state_d == ST_DONE);
`ifdef SEQ_TX_GAP_EN
        busy_d  = (state_d == ST_SEND) || (state_d == ST_GAP);
`else
        busy_d  = (state_d == ST_SEND);
`endif
    end

    assign ready = (state == ST_IDLE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx; expectations follow SEQ_TX_GAP_EN when it is defined.
module tb_seq_pattern_tx;

    localparam int unsigned PAT_W = 3;
    localparam int unsigned CNT_W = 4;
    localparam logic [2:0]  PAT   = 3'b101;
`ifdef SEQ_TX_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             ready, x, valid, last, busy, done;

    int tests = 0;
    int fails = 0;
    logic [15:0] cap_x;
    logic [15:0] cap_last;
    int          cap_n;

    seq_pattern_tx #(.PAT_W(PAT_W), .PATTERN(3'b101), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .count (count),
        .ready (ready),
        .x     (x),
        .valid (valid),
        .last  (last),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Vector order: {x, valid, last, busy, done, ready}
    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {x, valid, last, busy, done, ready};
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b (x,valid,last,busy,done,ready)", tag, obs, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected outputs k cycles after the start edge for a run of c repetitions
    function automatic logic [5:0] expect_at(input int k, input int c);
        int t;
        int l;
        int pos;
        int b;
        l = PAT_W + GAP;
        t = (c == 0) ? 0 : c * PAT_W + (c - 1) * GAP;
        if (k <= t) begin
            pos = (k - 1) % l;
            if (pos >= PAT_W) return 6'b000100;
            b = PAT_W - 1 - pos;
            return {PAT[b], 1'b1, (b == 0), 1'b1, 1'b0, 1'b0};
        end
        if (k == t + 1) return 6'b000010;
        return 6'b000001;
    endfunction

    // Launch a run and check every cycle through the following idle cycle
    task automatic run(input int c, input string tag, input int inject_k, input bit hold);
        int t;
        t = (c == 0) ? 0 : c * PAT_W + (c - 1) * GAP;
        cap_x = '0; cap_last = '0; cap_n = 0;
        count = CNT_W'(c);
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        for (int k = 1; k <= t + 2; k++) begin
            chk($sformatf("%s_k%0d", tag, k), expect_at(k, c));
            if (valid) begin
                cap_x    = {cap_x[14:0], x};
                cap_last = {cap_last[14:0], last};
                cap_n++;
            end
            if (k == inject_k) begin
                start = 1'b1;
                count = CNT_W'(5);
            end else if (!hold) begin
                start = 1'b0;
            end
            if (k < t + 2) step();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; count = '0;
        step();
        step();
        chk("reset", 6'b000001);
        rst = 1'b0;
        step();
        chk("idle_after_reset", 6'b000001);

        // Single repetition: 1,0,1 then done then ready
        run(1, "c1", 0, 1'b0);
        chk_val("c1_bits", cap_x, 16'h0005);
        chk_val("c1_last", cap_last, 16'h0001);

        // Three repetitions, serial stream check
        run(3, "c3", 0, 1'b0);
        chk_val("c3_bits", cap_x, 16'h016D);
        chk_val("c3_last", cap_last, 16'h0049);
        chk_val("c3_nvalid", 16'(cap_n), 16'd9);

        // Zero count: straight to done
        run(0, "c0", 0, 1'b0);
        chk_val("c0_nvalid", 16'(cap_n), 16'd0);
        step();
        chk("c0_stay_idle", 6'b000001);

        // Start during 2nd bit is ignored
        run(2, "ign", 2, 1'b0);
        chk_val("ign_nvalid", 16'(cap_n), 16'd6);
        step();
        chk("ign_no_restart", 6'b000001);

        // Maximum count
        run(15, "c15", 0, 1'b0);
        chk_val("c15_nvalid", 16'(cap_n), 16'd45);

        // Reset during 2nd bit abandons the run
        count = CNT_W'(2);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rst_mid_b1", 6'b110100);
        step();
        chk("rst_mid_b2", 6'b010100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_after", 6'b000001);
        step();
        chk("rst_mid_no_done", 6'b000001);
        run(1, "post_rst", 0, 1'b0);
        chk_val("post_rst_bits", cap_x, 16'h0005);

        // Reset and start together: start dropped
        rst = 1'b1; start = 1'b1; count = CNT_W'(2);
        step();
        rst = 1'b0; start = 1'b0;
        chk("rst_start_same", 6'b000001);
        step();
        chk("rst_start_idle", 6'b000001);

        // Back-to-back: start held, accepted in first IDLE cycle
        run(1, "b2b", 0, 1'b1);
        step();
        chk("b2b_restart_b1", 6'b110100);
        start = 1'b0;
        step();
        chk("b2b_restart_b2", 6'b010100);
        step();
        chk("b2b_restart_b3", 6'b111100);
        step();
        chk("b2b_restart_done", 6'b000010);
        step();
        chk("b2b_restart_idle", 6'b000001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
